multicycle_ctrl: RTL and testbench

Multicycle control FSM for the MIPS core. It sequences one shared ALU, one unified instruction/data memory port and the register file across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states. It uses the same opcode set and 4-bit ALU-op encoding as the single-cycle decoder. It sits between the IR/ALU-zero flag and every datapath mux/write-enable, and handshakes with a variable-latency memory.

---
 rtl/multicycle_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences the shared ALU, unified memory port and
// register file through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with a ready handshake.
module multicycle_ctrl #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [5:0]           instr_op_i,
    input  logic                 zero_i,
    input  logic                 mem_ready_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic                 iord_o,
    output logic                 ir_write_o,
    output logic                 pc_write_o,
    output logic [1:0]           pc_src_o,
    output logic                 alu_src_a_o,
    output logic [1:0]           alu_src_b_o,
    output logic [3:0]           alu_op_o,
    output logic                 reg_write_o,
    output logic [1:0]           reg_dst_o,
    output logic [1:0]           mem_to_reg_o,
    output logic                 illegal_o,
    output logic [3:0]           state_o,
    output logic [INSTRET_W-1:0] instret_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        ALU_R_TYPE = 4'd0,
        ALU_ADDI   = 4'd1,
        ALU_SLTIU  = 4'd2,
        ALU_BEQ    = 4'd3,
        ALU_LUI    = 4'd4,
        ALU_ORI    = 4'd5,
        ALU_BNE    = 4'd6
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_e                 state_q, state_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic                   retire;

    // ALU operation used in EXEC for the register/immediate arithmetic group.
    function automatic alu_op_e exec_alu_op(input logic [5:0] op);
        case (op)
            OP_ADDI:  return ALU_ADDI;
            OP_SLTIU: return ALU_SLTIU;
            OP_LUI:   return ALU_LUI;
            OP_ORI:   return ALU_ORI;
            default:  return ALU_R_TYPE;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (instr_op_i)
                    OP_RTYPE, OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI: state_d = S_EXEC;
                    OP_LW, OP_SW:                                state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                              state_d = S_BRANCH;
                    OP_J, OP_JAL:                                state_d = S_JUMP;
                    default:                                     state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = (instr_op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready_i) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_ready_i) state_d = S_FETCH;
            S_EXEC:     state_d = S_ALU_WB;
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Retirement happens on the final cycle of each legal instruction only.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEM_WR:                             retire = mem_ready_i;
            default:                              retire = 1'b0;
        endcase
        instret_d = instret_q + (retire ? INSTRET_W'(1) : INSTRET_W'(0));
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 2'd0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'd0;
        alu_op_o     = ALU_R_TYPE;
        reg_write_o  = 1'b0;
        reg_dst_o    = 2'd0;
        mem_to_reg_o = 2'd0;
        illegal_o    = 1'b0;
        state_o      = 4'd0;
        instret_o    = '0;
        // Reset masks everything, so a request pending in a wait state drops at once.
        if (!rst_i) begin
            state_o   = state_q;
            instret_o = instret_q;
            case (state_q)
                S_FETCH: begin
                    mem_req_o   = 1'b1;
                    alu_src_b_o = 2'd1;
                    alu_op_o    = ALU_ADDI;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                S_DECODE: begin
                    alu_src_b_o = 2'd3;
                    alu_op_o    = ALU_ADDI;
                    illegal_o   = (state_d == S_FETCH);
                end
                S_EXEC: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = (instr_op_i == OP_RTYPE) ? 2'd0 : 2'd2;
                    alu_op_o    = exec_alu_op(instr_op_i);
                end
                S_ALU_WB: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = (instr_op_i == OP_RTYPE) ? 2'd1 : 2'd0;
                end
                S_MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'd2;
                    alu_op_o    = ALU_ADDI;
                end
                S_MEM_RD: begin
                    mem_req_o = 1'b1;
                    iord_o    = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 2'd1;
                end
                S_MEM_WR: begin
                    mem_req_o = 1'b1;
                    mem_we_o  = 1'b1;
                    iord_o    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_o = 1'b1;
                    pc_src_o    = 2'd1;
                    if (instr_op_i == OP_BNE) begin
                        alu_op_o   = ALU_BNE;
                        pc_write_o = !zero_i;
                    end else begin
                        alu_op_o   = ALU_BEQ;
                        pc_write_o = zero_i;
                    end
                end
                S_JUMP: begin
                    pc_write_o = 1'b1;
                    pc_src_o   = 2'd2;
                    if (instr_op_i == OP_JAL) begin
                        reg_write_o  = 1'b1;
                        reg_dst_o    = 2'd2;
                        mem_to_reg_o = 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each cycle pushes the expected output
// vector to a scoreboard queue and pops it against the DUT at the falling edge.
module tb_multicycle_ctrl;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    typedef struct packed {
        logic [3:0]  state;
        logic        mem_req;
        logic        mem_we;
        logic        iord;
        logic        ir_write;
        logic        pc_write;
        logic [1:0]  pc_src;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        logic [3:0]  alu_op;
        logic        reg_write;
        logic [1:0]  reg_dst;
        logic [1:0]  mem_to_reg;
        logic        illegal;
        logic [31:0] instret;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i, zero_i, mem_ready_i;
    logic [5:0]  instr_op_i;
    logic        mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o;
    logic [1:0]  pc_src_o, alu_src_b_o, reg_dst_o, mem_to_reg_o;
    logic        alu_src_a_o, reg_write_o, illegal_o;
    logic [3:0]  alu_op_o, state_o;
    logic [31:0] instret_o;

    exp_t        sb_q[$];
    string       tag_q[$];
    logic [31:0] exp_ir = '0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.INSTRET_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .iord_o(iord_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
        .pc_src_o(pc_src_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .alu_op_o(alu_op_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
        .mem_to_reg_o(mem_to_reg_o), .illegal_o(illegal_o), .state_o(state_o),
        .instret_o(instret_o)
    );

    // Expected vectors per state, written straight from the state descriptions.
    function automatic exp_t e_base(input logic [3:0] st);
        exp_t e = '0;
        e.state   = st;
        e.instret = exp_ir;
        return e;
    endfunction

    function automatic exp_t e_rst();
        exp_t e = '0;
        return e;
    endfunction

    function automatic exp_t e_fetch(input logic rdy);
        exp_t e = e_base(4'd0);
        e.mem_req = 1'b1; e.alu_src_b = 2'd1; e.alu_op = 4'd1;
        e.ir_write = rdy; e.pc_write = rdy;
        return e;
    endfunction

    function automatic exp_t e_decode(input logic ill);
        exp_t e = e_base(4'd1);
        e.alu_src_b = 2'd3; e.alu_op = 4'd1; e.illegal = ill;
        return e;
    endfunction

    function automatic exp_t e_exec(input logic [3:0] code, input logic rtype);
        exp_t e = e_base(4'd6);
        e.alu_src_a = 1'b1; e.alu_src_b = rtype ? 2'd0 : 2'd2; e.alu_op = code;
        return e;
    endfunction

    function automatic exp_t e_alu_wb(input logic rtype);
        exp_t e = e_base(4'd7);
        e.reg_write = 1'b1; e.reg_dst = rtype ? 2'd1 : 2'd0;
        return e;
    endfunction

    function automatic exp_t e_mem_addr();
        exp_t e = e_base(4'd2);
        e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = 4'd1;
        return e;
    endfunction

    function automatic exp_t e_mem_rd();
        exp_t e = e_base(4'd3);
        e.mem_req = 1'b1; e.iord = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_mem_wb();
        exp_t e = e_base(4'd4);
        e.reg_write = 1'b1; e.mem_to_reg = 2'd1;
        return e;
    endfunction

    function automatic exp_t e_mem_wr();
        exp_t e = e_base(4'd5);
        e.mem_req = 1'b1; e.mem_we = 1'b1; e.iord = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_branch(input logic [3:0] code, input logic pcw);
        exp_t e = e_base(4'd8);
        e.alu_src_a = 1'b1; e.alu_op = code; e.pc_src = 2'd1; e.pc_write = pcw;
        return e;
    endfunction

    function automatic exp_t e_jump(input logic jal);
        exp_t e = e_base(4'd9);
        e.pc_write = 1'b1; e.pc_src = 2'd2;
        if (jal) begin
            e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
        end
        return e;
    endfunction

    // One clock cycle: drive inputs, queue the expectation, compare at negedge.
    task automatic cyc(input string tag, input logic rst, input logic [5:0] op,
                       input logic zero, input logic rdy, input exp_t exp);
        exp_t obs, e;
        string t;
        rst_i = rst; instr_op_i = op; zero_i = zero; mem_ready_i = rdy;
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        obs = '{state: state_o, mem_req: mem_req_o, mem_we: mem_we_o, iord: iord_o,
                ir_write: ir_write_o, pc_write: pc_write_o, pc_src: pc_src_o,
                alu_src_a: alu_src_a_o, alu_src_b: alu_src_b_o, alu_op: alu_op_o,
                reg_write: reg_write_o, reg_dst: reg_dst_o, mem_to_reg: mem_to_reg_o,
                illegal: illegal_o, instret: instret_o};
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        n_checks++;
        assert (obs === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %p expected %p", t, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_alu(input string tag, input logic [5:0] op, input logic [3:0] code);
        logic rt = (op == OP_RTYPE);
        cyc({tag, "_fetch"},  1'b0, op, 1'b0, 1'b1, e_fetch(1'b1));
        cyc({tag, "_decode"}, 1'b0, op, 1'b0, 1'b1, e_decode(1'b0));
        cyc({tag, "_exec"},   1'b0, op, 1'b0, 1'b1, e_exec(code, rt));
        cyc({tag, "_wb"},     1'b0, op, 1'b0, 1'b1, e_alu_wb(rt));
        exp_ir++;
    endtask

    task automatic run_lw(input string tag, input int fwait, input int mwait);
        for (int i = 0; i < fwait; i++)
            cyc({tag, "_fetch_wait"}, 1'b0, OP_LW, 1'b0, 1'b0, e_fetch(1'b0));
        cyc({tag, "_fetch"},    1'b0, OP_LW, 1'b0, 1'b1, e_fetch(1'b1));
        cyc({tag, "_decode"},   1'b0, OP_LW, 1'b0, 1'b1, e_decode(1'b0));
        cyc({tag, "_mem_addr"}, 1'b0, OP_LW, 1'b0, 1'b1, e_mem_addr());
        for (int i = 0; i < mwait; i++)
            cyc({tag, "_mem_rd_wait"}, 1'b0, OP_LW, 1'b0, 1'b0, e_mem_rd());
        cyc({tag, "_mem_rd"},   1'b0, OP_LW, 1'b0, 1'b1, e_mem_rd());
        cyc({tag, "_mem_wb"},   1'b0, OP_LW, 1'b0, 1'b1, e_mem_wb());
        exp_ir++;
    endtask

    task automatic run_br(input string tag, input logic [5:0] op, input logic zero,
                          input logic [3:0] code, input logic pcw);
        cyc({tag, "_fetch"},  1'b0, op, zero, 1'b1, e_fetch(1'b1));
        cyc({tag, "_decode"}, 1'b0, op, zero, 1'b1, e_decode(1'b0));
        cyc({tag, "_branch"}, 1'b0, op, zero, 1'b1, e_branch(code, pcw));
        exp_ir++;
    endtask

    task automatic run_sw_reset(input string tag, input logic rdy_at_rst);
        cyc({tag, "_fetch"},    1'b0, OP_SW, 1'b0, 1'b1, e_fetch(1'b1));
        cyc({tag, "_decode"},   1'b0, OP_SW, 1'b0, 1'b1, e_decode(1'b0));
        cyc({tag, "_mem_addr"}, 1'b0, OP_SW, 1'b0, 1'b1, e_mem_addr());
        cyc({tag, "_mem_wr_wait"}, 1'b0, OP_SW, 1'b0, 1'b0, e_mem_wr());
        cyc({tag, "_rst"},      1'b1, OP_SW, 1'b0, rdy_at_rst, e_rst());
        exp_ir = '0;
        cyc({tag, "_after_rst"}, 1'b0, OP_SW, 1'b0, 1'b0, e_fetch(1'b0));
        cyc({tag, "_after_rst2"}, 1'b0, OP_SW, 1'b0, 1'b1, e_fetch(1'b1));
        cyc({tag, "_decode2"},  1'b0, OP_SW, 1'b0, 1'b1, e_decode(1'b0));
        cyc({tag, "_mem_addr2"}, 1'b0, OP_SW, 1'b0, 1'b1, e_mem_addr());
        cyc({tag, "_mem_wr2"},  1'b0, OP_SW, 1'b0, 1'b1, e_mem_wr());
        exp_ir++;
    endtask

    initial begin
        rst_i = 1'b1; instr_op_i = '0; zero_i = 1'b0; mem_ready_i = 1'b0;
        @(posedge clk);
        #1;

        // Reset held three cycles, ready asserted to show it is ignored.
        for (int i = 0; i < 3; i++)
            cyc("reset_hold", 1'b1, OP_RTYPE, 1'b1, 1'b1, e_rst());

        // addi, R-type, lw, sw with zero-wait memory: 17 cycles, 4 retired.
        run_alu("addi", OP_ADDI, 4'd1);
        run_alu("rtype", OP_RTYPE, 4'd0);
        run_lw("lw", 0, 0);
        cyc("sw_fetch",    1'b0, OP_SW, 1'b0, 1'b1, e_fetch(1'b1));
        cyc("sw_decode",   1'b0, OP_SW, 1'b0, 1'b1, e_decode(1'b0));
        cyc("sw_mem_addr", 1'b0, OP_SW, 1'b0, 1'b1, e_mem_addr());
        cyc("sw_mem_wr",   1'b0, OP_SW, 1'b0, 1'b1, e_mem_wr());
        exp_ir++;

        // lw with three wait cycles on both accesses: 11 cycles total.
        run_lw("lw_slow", 3, 3);

        // Remaining immediate ALU mappings.
        run_alu("sltiu", OP_SLTIU, 4'd2);
        run_alu("lui", OP_LUI, 4'd4);
        run_alu("ori", OP_ORI, 4'd5);

        // Branch outcomes for both polarities of zero.
        run_br("beq_z1", OP_BEQ, 1'b1, 4'd3, 1'b1);
        run_br("bne_z1", OP_BNE, 1'b1, 4'd6, 1'b0);
        run_br("beq_z0", OP_BEQ, 1'b0, 4'd3, 1'b0);
        run_br("bne_z0", OP_BNE, 1'b0, 4'd6, 1'b1);

        // Jumps.
        cyc("jal_fetch",  1'b0, OP_JAL, 1'b0, 1'b1, e_fetch(1'b1));
        cyc("jal_decode", 1'b0, OP_JAL, 1'b0, 1'b1, e_decode(1'b0));
        cyc("jal_jump",   1'b0, OP_JAL, 1'b0, 1'b1, e_jump(1'b1));
        exp_ir++;
        cyc("j_fetch",    1'b0, OP_J, 1'b0, 1'b1, e_fetch(1'b1));
        cyc("j_decode",   1'b0, OP_J, 1'b0, 1'b1, e_decode(1'b0));
        cyc("j_jump",     1'b0, OP_J, 1'b0, 1'b1, e_jump(1'b0));
        exp_ir++;

        // Illegal opcode: pulse in DECODE, no retire, straight back to FETCH.
        cyc("ill_fetch",  1'b0, OP_BAD, 1'b0, 1'b1, e_fetch(1'b1));
        cyc("ill_decode", 1'b0, OP_BAD, 1'b0, 1'b1, e_decode(1'b1));
        run_alu("post_ill", OP_ADDI, 4'd1);

        // Reset during MEM_WR wait, then with ready arriving in the reset cycle.
        run_sw_reset("sw_rst_wait", 1'b0);
        run_sw_reset("sw_rst_ready", 1'b1);
        cyc("final_fetch", 1'b0, OP_RTYPE, 1'b0, 1'b0, e_fetch(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
